// File: rtl/score_overlay.sv
// Binary-to-BCD 7-segment score overlay for the VGA pixel pipeline.
// A sequential double-dabble converts the captured score. The displayed
// digits change only on frame_start, so a frame is never drawn half-updated.
module score_overlay #(
  parameter int          DIGITS       = 4,
  parameter int          SCORE_W      = 14,
  parameter int          X0           = 50,
  parameter int          Y0           = 139,
  parameter int          DIG_W        = 20,
  parameter int          DIG_PITCH    = 25,
  parameter int          SEG_V        = 5,
  parameter int          SEG_H        = 7,
  parameter logic [11:0] FG           = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  input  logic               frame_start,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               blank_lz,
  input  logic               blink_en,
  output logic               pixel_on,
  output logic [11:0]        pixel_rgb,
  output logic               in_region,
  output logic               busy,
  output logic               overflow
);

  localparam int BCD_W     = 4 * DIGITS;
  localparam int SH_W      = BCD_W + SCORE_W;
  localparam int CNT_W     = $clog2(SCORE_W + 1);
  localparam int BLK_W     = $clog2(BLINK_FRAMES + 1);
  localparam int MAX_SCORE = 10 ** DIGITS - 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] pending_q, pending_d;
  logic               req_q, req_d;
  logic               overflow_q, overflow_d;
  logic [SH_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   conv_bcd_q, conv_bcd_d;
  logic               conv_ready_q, conv_ready_d;
  logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               pix_on_q, pix_on_d;
  logic               region_q, region_d;

  // Segment order {a,b,c,d,e,f,g}; nibbles 10-15 stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // Score capture with saturation; a new capture always wins over IDLE consuming req.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    pending_d  = pending_q;
    req_d      = req_q;
    overflow_d = overflow_q;
    if (state_q == S_IDLE && req_q) req_d = 1'b0;
    if (score_valid) begin
      req_d = 1'b1;
      if (32'(score_in) > 32'(MAX_SCORE)) begin
        pending_d  = SCORE_W'(MAX_SCORE);
        overflow_d = 1'b1;
      end else begin
        pending_d = score_in;
      end
    end
  end

  // Double-dabble FSM next state plus the conversion and display hand-off.
  always_comb begin
    logic [SH_W-1:0] adj;
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    conv_bcd_d   = conv_bcd_q;
    conv_ready_d = conv_ready_q;
    disp_bcd_d   = disp_bcd_q;
    adj          = shift_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (shift_q[SCORE_W + 4*d +: 4] >= 4'd5)
        adj[SCORE_W + 4*d +: 4] = shift_q[SCORE_W + 4*d +: 4] + 4'd3;
    end
    // A DONE cycle blocks the load so the fresh result waits for the next frame.
    if (frame_start && conv_ready_q && state_q != S_DONE) begin
      disp_bcd_d   = conv_bcd_q;
      conv_ready_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (req_q) begin
          shift_d = {{BCD_W{1'b0}}, pending_q};
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = {adj[SH_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        conv_bcd_d   = shift_q[SH_W-1 -: BCD_W];
        conv_ready_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame-counted blink phase, held at zero while blinking is disabled.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Pixel hit test: bounding boxes, segment rectangles, leading-zero blanking, blink mask.
  always_comb begin
    int         xi, yi, l, r;
    logic [4:0] band;
    logic [6:0] seg;
    logic       seen_nz, show, in_x, left, right, lit;
    xi       = int'({22'd0, x});
    yi       = int'({22'd0, y});
    region_d = 1'b0;
    lit      = 1'b0;
    seen_nz  = 1'b0;
    for (int k = 0; k < 5; k++)
      band[k] = (yi >= Y0 + k*SEG_H) && (yi <= Y0 + (k+1)*SEG_H - 1);
    for (int i = 0; i < DIGITS; i++) begin
      l = X0 + i*DIG_PITCH;
      r = l + DIG_W - 1;
      if (disp_bcd_q[4*(DIGITS-1-i) +: 4] != 4'd0) seen_nz = 1'b1;
      show  = !blank_lz || seen_nz || (i == DIGITS - 1);
      seg   = seg_decode(disp_bcd_q[4*(DIGITS-1-i) +: 4]);
      in_x  = (xi >= l) && (xi <= r);
      left  = xi <= l + SEG_V - 1;
      right = xi >= r - SEG_V + 1;
      if (in_x && (band != 5'd0)) begin
        region_d = 1'b1;
        if (show)
          lit = lit | (band[0] & seg[6])
                    | (band[1] & ((left & seg[1]) | (right & seg[5])))
                    | (band[2] & seg[0])
                    | (band[3] & ((left & seg[2]) | (right & seg[4])))
                    | (band[4] & seg[3]);
      end
    end
    pix_on_d = lit & ~(blink_en & phase_q);
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      req_q        <= 1'b0;
      overflow_q   <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      conv_bcd_q   <= '0;
      conv_ready_q <= 1'b0;
      disp_bcd_q   <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pix_on_q     <= 1'b0;
      region_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      req_q        <= req_d;
      overflow_q   <= overflow_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      conv_bcd_q   <= conv_bcd_d;
      conv_ready_q <= conv_ready_d;
      disp_bcd_q   <= disp_bcd_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      pix_on_q     <= pix_on_d;
      region_q     <= region_d;
    end
  end

  assign pixel_on  = pix_on_q;
  assign pixel_rgb = pix_on_q ? FG : 12'h000;
  assign in_region = region_q;
  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_score_overlay.sv
// Scoreboard bench for score_overlay: stimulus pushes expected pixel/status
// responses, a negedge monitor pops and compares them one cycle later.
module tb_score_overlay;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [13:0] score_in = '0;
  logic        score_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        blank_lz = 1'b1;
  logic        blink_en = 1'b0;
  logic        pixel_on;
  logic [11:0] pixel_rgb;
  logic        in_region;
  logic        busy;
  logic        overflow;

  always #5 clk = ~clk;

  score_overlay #(.BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .score_in   (score_in),
    .score_valid(score_valid),
    .frame_start(frame_start),
    .x          (x),
    .y          (y),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .pixel_on   (pixel_on),
    .pixel_rgb  (pixel_rgb),
    .in_region  (in_region),
    .busy       (busy),
    .overflow   (overflow)
  );

  typedef struct {
    string name;
    logic  on;
    logic  region;
    logic  chk_stat;
    logic  busy;
    logic  ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic probe = 1'b0;
  logic probe_d = 1'b0;

  // Marks the cycle whose registered outputs belong to a probe.
  always_ff @(posedge clk) probe_d <= probe;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented probe result.
  always @(negedge clk) begin
    if (probe_d) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_on"},     int'(pixel_on),  int'(e.on));
        check({e.name, "_rgb"},    int'(pixel_rgb), e.on ? 32'hFFF : 0);
        check({e.name, "_region"}, int'(in_region), int'(e.region));
        if (e.chk_stat) begin
          check({e.name, "_busy"},     int'(busy),     int'(e.busy));
          check({e.name, "_overflow"}, int'(overflow), int'(e.ovf));
        end
      end
    end
  end

  task automatic probe_px(input string name, input int px, input int py,
                          input logic on, input logic region);
    @(posedge clk); #1;
    x = 10'(px); y = 10'(py); probe = 1'b1;
    sb_q.push_back('{name, on, region, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic probe_st(input string name, input int px, input int py,
                          input logic on, input logic region,
                          input logic exp_busy, input logic exp_ovf);
    @(posedge clk); #1;
    x = 10'(px); y = 10'(py); probe = 1'b1;
    sb_q.push_back('{name, on, region, 1'b1, exp_busy, exp_ovf});
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic capture(input int v);
    @(posedge clk); #1;
    score_in = 14'(v); score_valid = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Waits for three consecutive idle cycles so the gap between chained conversions is skipped.
  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int n = 0; n < 80 && quiet < 3; n++) begin
      @(posedge clk); #1;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 3) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: busy still %0b, required 0 within 80 cycles", name, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before time 100000");
    $fatal(1);
  end

  initial begin
    logic [5:0] blink_exp;
    blink_exp = 6'b110011;

    // 1: reset state, units digit shows 0, other digits blanked
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    probe_st("t1_units_a", 130, 142, 1'b1, 1'b1, 1'b0, 1'b0);
    probe_px("t1_msd_blank", 55, 142, 1'b0, 1'b1);
    probe_px("t1_gap", 72, 142, 1'b0, 1'b0);

    // 2: convert 1234, display holds until frame_start
    capture(1234);
    probe_st("t2_busy", 105, 156, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_idle("t2");
    probe_st("t2_hold", 105, 156, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    probe_px("t2_tens_g", 105, 156, 1'b1, 1'b1);
    probe_px("t2_hund_e", 77, 163, 1'b1, 1'b1);
    probe_px("t2_thou_e", 52, 163, 1'b0, 1'b1);
    probe_px("t2_units_a", 130, 142, 1'b0, 1'b1);

    // 3: saturation to 9999
    capture(12000);
    wait_idle("t3");
    probe_st("t3_ovf", 127, 163, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_frame();
    probe_px("t3_units_e", 127, 163, 1'b0, 1'b1);
    probe_px("t3_msd_a", 55, 142, 1'b1, 1'b1);
    probe_px("t3_units_g", 130, 156, 1'b1, 1'b1);

    // 4: second capture while busy, last write wins
    capture(5);
    repeat (3) @(posedge clk);
    capture(7);
    wait_idle("t4");
    pulse_frame();
    probe_px("t4_units_a", 130, 142, 1'b1, 1'b1);
    probe_px("t4_units_g", 130, 156, 1'b0, 1'b1);
    probe_st("t4_msd_blank", 55, 142, 1'b0, 1'b1, 1'b0, 1'b1);

    // 5: blink with two frames per half-period
    capture(8);
    wait_idle("t5");
    pulse_frame();
    blink_en = 1'b1;
    probe_px("t5_frame0", 130, 156, blink_exp[0], 1'b1);
    for (int k = 1; k < 6; k++) begin
      pulse_frame();
      probe_px($sformatf("t5_frame%0d", k), 130, 156, blink_exp[k], 1'b1);
    end
    blink_en = 1'b0;

    // 6: reset during SHIFT aborts conversion, nothing loads afterwards
    capture(999);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    probe_st("t6_after_rst", 130, 142, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    probe_px("t6_units_g", 130, 156, 1'b0, 1'b1);
    probe_px("t6_msd_blank", 55, 142, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
